// File: rtl/alu_issue_stage_pkg.sv
// Shared encodings for the ALU interface: ALU_CTRL codes, RV32I opcodes,
// branch-condition tags and operand-select enums.
package alu_issue_stage_pkg;

  localparam logic [3:0] ALU_NOP  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SGE  = 4'b0011;
  localparam logic [3:0] ALU_SGEU = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0101;
  localparam logic [3:0] ALU_ADD  = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;
  localparam logic [3:0] ALU_SLL  = 4'b1010;
  localparam logic [3:0] ALU_SRL  = 4'b1011;
  localparam logic [3:0] ALU_SRA  = 4'b1100;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_EQ   = 3'd1;
  localparam logic [2:0] BR_NE   = 3'd2;
  localparam logic [2:0] BR_LT   = 3'd3;
  localparam logic [2:0] BR_GE   = 3'd4;
  localparam logic [2:0] BR_LTU  = 3'd5;
  localparam logic [2:0] BR_GEU  = 3'd6;

  typedef enum logic [1:0] {IN1_ZERO, IN1_RS1, IN1_PC} in1_sel_e;
  typedef enum logic [1:0] {IN2_ZERO, IN2_RS2, IN2_IMM, IN2_FOUR} in2_sel_e;

  // The ALU shifts by the whole of In2, so shift operands must be masked to 5 bits.
  function automatic logic is_shift(input logic [3:0] ctrl);
    return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_issue_stage_alu_ctrl_decode.sv
// Combinational opcode/funct decode into ALU_CTRL, operand selects, branch tag
// and illegal flag. Illegal encodings produce a NOP with zero operands.
module alu_ctrl_decode
  import alu_issue_stage_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] ctrl,
  output in1_sel_e   sel_in1,
  output in2_sel_e   sel_in2,
  output logic [2:0] br_cond,
  output logic       is_store,
  output logic       illegal
);

  // Shared OP / OP-IMM funct3 map; SUB exists only in the register form.
  function automatic logic [3:0] arith_ctrl(input logic [2:0] f3, input logic alt,
                                            input logic reg_form);
    logic [3:0] c;
    case (f3)
      3'b000:  c = (alt && reg_form) ? ALU_SUB : ALU_ADD;
      3'b001:  c = ALU_SLL;
      3'b010:  c = ALU_SLT;
      3'b011:  c = ALU_SLTU;
      3'b100:  c = ALU_XOR;
      3'b101:  c = alt ? ALU_SRA : ALU_SRL;
      3'b110:  c = ALU_OR;
      default: c = ALU_AND;
    endcase
    return c;
  endfunction

  // Opcode-level decode with safe NOP defaults.
  always_comb begin
    ctrl     = ALU_NOP;
    sel_in1  = IN1_ZERO;
    sel_in2  = IN2_ZERO;
    br_cond  = BR_NONE;
    is_store = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OPC_OP: begin
        ctrl = arith_ctrl(funct3, funct7b5, 1'b1);
        sel_in1 = IN1_RS1; sel_in2 = IN2_RS2;
      end
      OPC_OP_IMM: begin
        ctrl = arith_ctrl(funct3, funct7b5, 1'b0);
        sel_in1 = IN1_RS1; sel_in2 = IN2_IMM;
      end
      OPC_LUI:   begin ctrl = ALU_ADD; sel_in1 = IN1_ZERO; sel_in2 = IN2_IMM;  end
      OPC_AUIPC: begin ctrl = ALU_ADD; sel_in1 = IN1_PC;   sel_in2 = IN2_IMM;  end
      OPC_JAL, OPC_JALR: begin
        ctrl = ALU_ADD; sel_in1 = IN1_PC; sel_in2 = IN2_FOUR;
      end
      OPC_LOAD:  begin ctrl = ALU_ADD; sel_in1 = IN1_RS1; sel_in2 = IN2_IMM; end
      OPC_STORE: begin
        ctrl = ALU_ADD; sel_in1 = IN1_RS1; sel_in2 = IN2_IMM; is_store = 1'b1;
      end
      OPC_BRANCH: begin
        sel_in1 = IN1_RS1; sel_in2 = IN2_RS2;
        case (funct3)
          3'b000:  begin ctrl = ALU_SUB;  br_cond = BR_EQ;  end
          3'b001:  begin ctrl = ALU_SUB;  br_cond = BR_NE;  end
          3'b100:  begin ctrl = ALU_SLT;  br_cond = BR_LT;  end
          3'b101:  begin ctrl = ALU_SGE;  br_cond = BR_GE;  end
          3'b110:  begin ctrl = ALU_SLTU; br_cond = BR_LTU; end
          3'b111:  begin ctrl = ALU_SGEU; br_cond = BR_GEU; end
          default: begin
            illegal = 1'b1; sel_in1 = IN1_ZERO; sel_in2 = IN2_ZERO;
          end
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: one pipeline register with valid/ready handshake that
// drives the ALU operands, control code and branch tag directly.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [6:0]        id_opcode,
  input  logic [2:0]        id_funct3,
  input  logic              id_funct7b5,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_val,
  input  logic [XLEN-1:0]   id_rs2_val,
  input  logic [XLEN-1:0]   id_imm,
  input  logic              flush,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   alu_in1,
  output logic [XLEN-1:0]   alu_in2,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [2:0]        ex_br_cond,
  output logic [XLEN-1:0]   ex_store_val,
  output logic              ex_illegal
);

  logic [3:0]      ctrl_p0;
  in1_sel_e        sel_in1_p0;
  in2_sel_e        sel_in2_p0;
  logic [2:0]      br_p0;
  logic            store_p0;
  logic            ill_p0;
  logic [XLEN-1:0] in1_p0, in2_raw_p0, in2_p0, store_val_p0;
  logic            load_p0;

  logic              vld_p1;
  logic [XLEN-1:0]   in1_p1, in2_p1, store_val_p1;
  logic [CTRL_W-1:0] ctrl_p1;
  logic [2:0]        br_p1;
  logic              ill_p1;

  // ---- p0: decode and operand select (ID side) ----
  alu_ctrl_decode u_dec (
    .opcode   (id_opcode),
    .funct3   (id_funct3),
    .funct7b5 (id_funct7b5),
    .ctrl     (ctrl_p0),
    .sel_in1  (sel_in1_p0),
    .sel_in2  (sel_in2_p0),
    .br_cond  (br_p0),
    .is_store (store_p0),
    .illegal  (ill_p0)
  );

  // Operand muxes; shift amounts are masked to the low 5 bits of their source.
  always_comb begin
    in1_p0 = '0;
    case (sel_in1_p0)
      IN1_RS1: in1_p0 = id_rs1_val;
      IN1_PC:  in1_p0 = id_pc;
      default: in1_p0 = '0;
    endcase
    in2_raw_p0 = '0;
    case (sel_in2_p0)
      IN2_RS2:  in2_raw_p0 = id_rs2_val;
      IN2_IMM:  in2_raw_p0 = id_imm;
      IN2_FOUR: in2_raw_p0 = XLEN'(4);
      default:  in2_raw_p0 = '0;
    endcase
    in2_p0       = is_shift(ctrl_p0) ? {{(XLEN-5){1'b0}}, in2_raw_p0[4:0]} : in2_raw_p0;
    store_val_p0 = store_p0 ? id_rs2_val : '0;
  end

  assign id_ready = !vld_p1 || ex_ready;
  assign load_p0  = id_valid && id_ready && !flush;

  // ---- p1: issue register (EX side); flush beats load, load beats drain ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1       <= 1'b0;
      in1_p1       <= '0;
      in2_p1       <= '0;
      ctrl_p1      <= '0;
      br_p1        <= BR_NONE;
      store_val_p1 <= '0;
      ill_p1       <= 1'b0;
    end else if (flush) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
    end else if (load_p0) begin
      vld_p1       <= 1'b1;
      in1_p1       <= in1_p0;
      in2_p1       <= in2_p0;
      ctrl_p1      <= CTRL_W'(ctrl_p0);
      br_p1        <= br_p0;
      store_val_p1 <= store_val_p0;
      ill_p1       <= ill_p0;
    end else if (ex_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign ex_valid     = vld_p1;
  assign alu_in1      = in1_p1;
  assign alu_in2      = in2_p1;
  assign alu_ctrl     = ctrl_p1;
  assign ex_br_cond   = br_p1;
  assign ex_store_val = store_val_p1;
  assign ex_illegal   = ill_p1;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed cases plus randomized traffic, with a
// scoreboard queue filled on each accepted instruction and drained by a monitor.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic        id_ready;
  logic [6:0]  id_opcode = '0;
  logic [2:0]  id_funct3 = '0;
  logic        id_funct7b5 = 1'b0;
  logic [31:0] id_pc = '0, id_rs1_val = '0, id_rs2_val = '0, id_imm = '0;
  logic        flush = 1'b0;
  logic        ex_valid;
  logic        ex_ready = 1'b1;
  logic [31:0] alu_in1, alu_in2, ex_store_val;
  logic [3:0]  alu_ctrl;
  logic [2:0]  ex_br_cond;
  logic        ex_illegal;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] in1, in2, store;
    logic [3:0]  ctrl;
    logic [2:0]  br;
    logic        ill;
  } exp_t;

  exp_t sb[$];

  alu_issue_stage #(.XLEN(32), .CTRL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
    .id_pc(id_pc), .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
    .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl),
    .ex_br_cond(ex_br_cond), .ex_store_val(ex_store_val), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what the ALU must be told for an RV32I instruction.
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                 input logic [31:0] pc, rs1, rs2, imm);
    exp_t e;
    logic [31:0] b;
    e = '{in1: 32'd0, in2: 32'd0, store: 32'd0, ctrl: 4'd0, br: 3'd0, ill: 1'b0};
    case (op)
      7'h33, 7'h13: begin
        b = (op == 7'h33) ? rs2 : imm;
        e.in1 = rs1; e.in2 = b;
        case (f3)
          3'd0: e.ctrl = (op == 7'h33 && f7) ? 4'd1 : 4'd6;
          3'd1: begin e.ctrl = 4'd10; e.in2 = b % 32; end
          3'd2: e.ctrl = 4'd2;
          3'd3: e.ctrl = 4'd5;
          3'd4: e.ctrl = 4'd7;
          3'd5: begin e.ctrl = f7 ? 4'd12 : 4'd11; e.in2 = b % 32; end
          3'd6: e.ctrl = 4'd8;
          default: e.ctrl = 4'd9;
        endcase
      end
      7'h37: begin e.in2 = imm; e.ctrl = 4'd6; end
      7'h17: begin e.in1 = pc; e.in2 = imm; e.ctrl = 4'd6; end
      7'h6F, 7'h67: begin e.in1 = pc; e.in2 = 32'd4; e.ctrl = 4'd6; end
      7'h03: begin e.in1 = rs1; e.in2 = imm; e.ctrl = 4'd6; end
      7'h23: begin e.in1 = rs1; e.in2 = imm; e.ctrl = 4'd6; e.store = rs2; end
      7'h63: begin
        e.in1 = rs1; e.in2 = rs2;
        case (f3)
          3'd0: begin e.ctrl = 4'd1; e.br = 3'd1; end
          3'd1: begin e.ctrl = 4'd1; e.br = 3'd2; end
          3'd4: begin e.ctrl = 4'd2; e.br = 3'd3; end
          3'd5: begin e.ctrl = 4'd3; e.br = 3'd4; end
          3'd6: begin e.ctrl = 4'd5; e.br = 3'd5; end
          3'd7: begin e.ctrl = 4'd4; e.br = 3'd6; end
          default: begin e.in1 = 0; e.in2 = 0; e.ill = 1'b1; end
        endcase
      end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Monitor/scoreboard: sampled on the falling edge, where inputs for the next edge are stable.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
    end else begin
      chk("ex_valid_vs_pending", {31'd0, ex_valid}, {31'd0, sb.size() != 0});
      chk("id_ready", {31'd0, id_ready}, {31'd0, !ex_valid || ex_ready});
      if (ex_valid && sb.size() != 0) begin
        if (flush) begin
          void'(sb.pop_front());
        end else if (ex_ready) begin
          e = sb.pop_front();
          chk("sb_in1", alu_in1, e.in1);
          chk("sb_in2", alu_in2, e.in2);
          chk("sb_ctrl", {28'd0, alu_ctrl}, {28'd0, e.ctrl});
          chk("sb_br", {29'd0, ex_br_cond}, {29'd0, e.br});
          chk("sb_store", ex_store_val, e.store);
          chk("sb_ill", {31'd0, ex_illegal}, {31'd0, e.ill});
        end
      end
      if (id_valid && id_ready && !flush)
        sb.push_back(model(id_opcode, id_funct3, id_funct7b5, id_pc, id_rs1_val,
                           id_rs2_val, id_imm));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [31:0] pc, rs1, rs2, imm);
    id_valid = 1'b1; id_opcode = op; id_funct3 = f3; id_funct7b5 = f7;
    id_pc = pc; id_rs1_val = rs1; id_rs2_val = rs2; id_imm = imm;
  endtask

  logic [6:0] opc_tab [0:9] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67,
                                7'h03, 7'h23, 7'h63, 7'h7F};

  initial begin
    // Reset state
    #22;
    chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_in1", alu_in1, 32'd0);
    chk("rst_in2", alu_in2, 32'd0);
    chk("rst_ctrl", {28'd0, alu_ctrl}, 32'd0);
    chk("rst_br", {29'd0, ex_br_cond}, 32'd0);
    chk("rst_store", ex_store_val, 32'd0);
    chk("rst_ill", {31'd0, ex_illegal}, 32'd0);
    chk("rst_id_ready", {31'd0, id_ready}, 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;

    // Directed functional cases
    drive(7'h33, 3'd0, 1'b0, 32'h0, 32'd5, 32'd7, 32'h0); tick();
    chk("add_valid", {31'd0, ex_valid}, 32'd1);
    chk("add_ctrl", {28'd0, alu_ctrl}, 32'd6);
    chk("add_in1", alu_in1, 32'd5);
    chk("add_in2", alu_in2, 32'd7);
    drive(7'h33, 3'd5, 1'b1, 32'h0, 32'h80000000, 32'h21, 32'h0); tick();
    chk("sra_ctrl", {28'd0, alu_ctrl}, 32'd12);
    chk("sra_in2", alu_in2, 32'h1);
    drive(7'h63, 3'd7, 1'b0, 32'h0, 32'd3, 32'd9, 32'h0); tick();
    chk("bgeu_ctrl", {28'd0, alu_ctrl}, 32'd4);
    chk("bgeu_br", {29'd0, ex_br_cond}, 32'd6);
    drive(7'h63, 3'd1, 1'b0, 32'h0, 32'd3, 32'd9, 32'h0); tick();
    chk("bne_ctrl", {28'd0, alu_ctrl}, 32'd1);
    chk("bne_br", {29'd0, ex_br_cond}, 32'd2);
    drive(7'h6F, 3'd0, 1'b0, 32'h100, 32'd1, 32'd2, 32'h40); tick();
    chk("jal_in1", alu_in1, 32'h100);
    chk("jal_in2", alu_in2, 32'd4);
    chk("jal_ctrl", {28'd0, alu_ctrl}, 32'd6);
    drive(7'h23, 3'd2, 1'b0, 32'h0, 32'h1000, 32'hCAFE, 32'h8); tick();
    chk("sw_store", ex_store_val, 32'hCAFE);
    drive(7'h7F, 3'd0, 1'b0, 32'h0, 32'd1, 32'd2, 32'd3); tick();
    chk("ill_flag", {31'd0, ex_illegal}, 32'd1);
    chk("ill_ctrl", {28'd0, alu_ctrl}, 32'd0);
    chk("ill_valid", {31'd0, ex_valid}, 32'd1);
    id_valid = 1'b0; tick();
    chk("drain_valid", {31'd0, ex_valid}, 32'd0);

    // Stall: held instr frozen, second accepted once ex_ready returns
    ex_ready = 1'b0;
    drive(7'h33, 3'd0, 1'b0, 32'h0, 32'd1, 32'd2, 32'h0); tick();
    drive(7'h33, 3'd4, 1'b0, 32'h0, 32'hF0, 32'h0F, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_id_ready", {31'd0, id_ready}, 32'd0);
      chk("stall_in1", alu_in1, 32'd1);
      chk("stall_ctrl", {28'd0, alu_ctrl}, 32'd6);
      tick();
    end
    ex_ready = 1'b1; tick();
    chk("stall_next_ctrl", {28'd0, alu_ctrl}, 32'd7);
    chk("stall_next_in1", alu_in1, 32'hF0);
    chk("stall_next_valid", {31'd0, ex_valid}, 32'd1);
    id_valid = 1'b0; tick();

    // Flush with a held instr and a new one offered
    ex_ready = 1'b0;
    drive(7'h33, 3'd6, 1'b0, 32'h0, 32'd4, 32'd8, 32'h0); tick();
    drive(7'h13, 3'd0, 1'b0, 32'h0, 32'd9, 32'd9, 32'd9); flush = 1'b1; tick();
    chk("flush_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_ctrl", {28'd0, alu_ctrl}, 32'd0);
    flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1; tick();
    chk("flush_nothing", {31'd0, ex_valid}, 32'd0);

    // Asynchronous reset while stalled
    ex_ready = 1'b0;
    drive(7'h37, 3'd0, 1'b0, 32'h0, 32'd0, 32'd0, 32'h12345000); tick();
    id_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, ex_valid}, 32'd0);
    chk("arst_in2", alu_in2, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    chk("arst_id_ready", {31'd0, id_ready}, 32'd1);
    ex_ready = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [6:0] op;
      logic [31:0] r1, r2, im;
      op = ($urandom_range(0, 30) == 0) ? 7'($urandom) : opc_tab[$urandom_range(0, 9)];
      r1 = $urandom; r2 = $urandom; im = $urandom;
      drive(op, 3'($urandom), 1'($urandom), $urandom, r1, r2, im);
      id_valid = ($urandom_range(0, 3) != 0);
      ex_ready = ($urandom_range(0, 9) < 7);
      flush    = ($urandom_range(0, 19) == 0);
      tick();
    end
    id_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    tick(); tick(); tick();
    chk("final_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
